// File: rtl/md_unit_if.sv
// EX-stage multiply/divide port bundle: the master drives operands and control,
// and the slave (md_unit) returns HI/LO and status.
interface md_unit_if #(parameter int WIDTH = 32);
  logic             StartE;
  logic [1:0]       MDOpE;
  logic [WIDTH-1:0] SrcAE;
  logic [WIDTH-1:0] SrcBE;
  logic             WrHiE;
  logic             WrLoE;
  logic [WIDTH-1:0] WrDataE;
  logic             FlushE;
  logic [WIDTH-1:0] HiOut;
  logic [WIDTH-1:0] LoOut;
  logic             BusyE;
  logic             DoneM;

  modport master (
    output StartE, MDOpE, SrcAE, SrcBE, WrHiE, WrLoE, WrDataE, FlushE,
    input  HiOut, LoOut, BusyE, DoneM
  );

  modport slave (
    input  StartE, MDOpE, SrcAE, SrcBE, WrHiE, WrLoE, WrDataE, FlushE,
    output HiOut, LoOut, BusyE, DoneM
  );
endinterface

// File: rtl/md_unit.sv
// Iterative MIPS multiply/divide unit owning HI/LO: 32-step shift-add multiply,
// 32-step restoring divide and a sign-fix cycle, giving a fixed 33-cycle busy window.
module md_unit #(
  parameter int WIDTH = 32
) (
  input logic      clk,
  input logic      reset_n,
  md_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  state_t             state_reg;
  logic [5:0]         cnt_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [WIDTH-1:0]   mag_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               negq_reg;
  logic               negr_reg;
  logic               divz_reg;
  logic               isdiv_reg;
  logic               busy_reg;
  logic               done_reg;

  logic               op_div;
  logic               sign_a;
  logic               sign_b;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_next;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   lo_fix;
  logic [WIDTH-1:0]   hi_fix;

  // MDOpE[0] = 0 selects the signed variant, MDOpE[1] = 1 selects divide.
  assign op_div = bus.MDOpE[1];
  assign sign_a = ~bus.MDOpE[0] & bus.SrcAE[WIDTH-1];
  assign sign_b = ~bus.MDOpE[0] & bus.SrcBE[WIDTH-1];
  assign mag_a  = sign_a ? -bus.SrcAE : bus.SrcAE;
  assign mag_b  = sign_b ? -bus.SrcBE : bus.SrcBE;

  // Multiply: the multiplier sits in the low half and is consumed from bit 0
  // while the product grows into the high half.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, mag_reg};
  assign mul_next = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // Divide: the partial remainder is 33 bits wide after the shift, so the
  // bit shifted out of the top of acc takes part in the trial subtraction.
  assign div_diff = acc_reg[2*WIDTH-1:WIDTH-1] - {1'b0, mag_reg};
  assign div_next = div_diff[WIDTH] ? {acc_reg[2*WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  assign prod_fix = negq_reg ? -acc_reg : acc_reg;
  assign quot     = acc_reg[WIDTH-1:0];
  assign rem      = acc_reg[2*WIDTH-1:WIDTH];
  // For a zero divisor the remainder is |A| and negR is A's sign, so HI comes back as A.
  assign lo_fix   = divz_reg ? {WIDTH{1'b1}} : (negq_reg ? -quot : quot);
  assign hi_fix   = negr_reg ? -rem : rem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      acc_reg   <= '0;
      mag_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      negq_reg  <= 1'b0;
      negr_reg  <= 1'b0;
      divz_reg  <= 1'b0;
      isdiv_reg <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!bus.FlushE) begin
            if (bus.StartE) begin
              state_reg <= op_div ? DIV : MUL;
              busy_reg  <= 1'b1;
              cnt_reg   <= '0;
              acc_reg   <= {{WIDTH{1'b0}}, (op_div ? mag_a : mag_b)};
              mag_reg   <= op_div ? mag_b : mag_a;
              negq_reg  <= sign_a ^ sign_b;
              negr_reg  <= sign_a;
              divz_reg  <= op_div && (bus.SrcBE == '0);
              isdiv_reg <= op_div;
            end else begin
              if (bus.WrHiE) hi_reg <= bus.WrDataE;
              if (bus.WrLoE) lo_reg <= bus.WrDataE;
            end
          end
        end
        MUL, DIV: begin
          if (bus.FlushE) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            acc_reg <= (state_reg == DIV) ? div_next : mul_next;
            cnt_reg <= cnt_reg + 6'd1;
            if (cnt_reg == 6'd31) state_reg <= FIX;
          end
        end
        FIX: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          if (!bus.FlushE) begin
            done_reg <= 1'b1;
            if (isdiv_reg) begin
              hi_reg <= hi_fix;
              lo_reg <= lo_fix;
            end else begin
              hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
              lo_reg <= prod_fix[WIDTH-1:0];
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.HiOut = hi_reg;
  assign bus.LoOut = lo_reg;
  assign bus.BusyE = busy_reg;
  assign bus.DoneM = done_reg;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of MULT/DIV vectors with a result
// scoreboard, plus hand-written flush, reset and MTHI/MTLO sequences.
module tb_md_unit;
  logic clk;
  logic reset_n;

  md_unit_if #(.WIDTH(32)) bus ();

  md_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          poke;
  } vec_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  vec_t vecs[12];
  res_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa;
    longint          sb;
    longint unsigned ua;
    longint unsigned ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op)
      2'b00:   return 64'(sa * sb);
      2'b01:   return ua * ub;
      2'b10:   return {32'(sa % sb), 32'(sa / sb)};
      default: return {32'(ua % ub), 32'(ua / ub)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input bit wr_hi_at_start, input bit poke_busy);
    res_t r;
    int   busy_cnt;
    int   cyc;
    r.hi = exp_hi;
    r.lo = exp_lo;
    sb_q.push_back(r);
    bus.StartE  = 1'b1;
    bus.MDOpE   = op;
    bus.SrcAE   = a;
    bus.SrcBE   = b;
    bus.WrHiE   = wr_hi_at_start;
    bus.WrDataE = 32'h1111_2222;
    tick();
    bus.StartE = 1'b0;
    bus.WrHiE  = 1'b0;
    bus.SrcAE  = $urandom;
    bus.SrcBE  = $urandom;
    busy_cnt = 0;
    cyc = 0;
    while (!bus.DoneM && cyc < 100) begin
      if (bus.BusyE) busy_cnt++;
      if (poke_busy && cyc == 5) begin
        bus.StartE  = 1'b1;
        bus.WrHiE   = 1'b1;
        bus.WrLoE   = 1'b1;
        bus.WrDataE = 32'hDEAD_BEEF;
      end else begin
        bus.StartE = 1'b0;
        bus.WrHiE  = 1'b0;
        bus.WrLoE  = 1'b0;
      end
      tick();
      cyc++;
    end
    check("done_latency", 64'(cyc), 64'd33);
    check("busy_cycles", 64'(busy_cnt), 64'd33);
    if (sb_q.size() != 0) begin
      r = sb_q.pop_front();
      check("hi_result", bus.HiOut, r.hi);
      check("lo_result", bus.LoOut, r.lo);
    end else begin
      check("scoreboard_nonempty", 64'd0, 64'd1);
    end
    $display("op=%b a=%h b=%h -> hi=%h lo=%h busy=%0d", op, a, b, bus.HiOut, bus.LoOut, busy_cnt);
    tick();
    check("done_single_pulse", bus.DoneM, 1'b0);
    check("busy_after_done", bus.BusyE, 1'b0);
  endtask

  initial begin
    int       done_seen;
    logic [63:0] m;

    reset_n     = 1'b0;
    bus.StartE  = 1'b0;
    bus.MDOpE   = 2'b00;
    bus.SrcAE   = '0;
    bus.SrcBE   = '0;
    bus.WrHiE   = 1'b0;
    bus.WrLoE   = 1'b0;
    bus.WrDataE = '0;
    bus.FlushE  = 1'b0;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4] = '{2'b11, 32'h0000_0055, 32'h0000_0000, 32'h0000_0055, 32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0};
    vecs[6] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[7] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0000_000F, 32'h0FFF_FFFF, 1'b0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].op   = 2'(i % 4);
      vecs[i].a    = $urandom;
      vecs[i].b    = $urandom;
      if (vecs[i].b == 32'h0) vecs[i].b = 32'h1;
      m            = model(vecs[i].op, vecs[i].a, vecs[i].b);
      vecs[i].hi   = m[63:32];
      vecs[i].lo   = m[31:0];
      vecs[i].poke = 1'b0;
    end

    // Reset state
    tick();
    tick();
    check("reset_hi", bus.HiOut, 32'h0);
    check("reset_lo", bus.LoOut, 32'h0);
    check("reset_busy", bus.BusyE, 1'b0);
    check("reset_done", bus.DoneM, 1'b0);
    reset_n = 1'b1;
    tick();

    // MTHI/MTLO in idle, both together then each alone
    bus.WrHiE = 1'b1; bus.WrLoE = 1'b1; bus.WrDataE = 32'h0000_CCCC;
    tick();
    check("mthi_mtlo_hi", bus.HiOut, 32'h0000_CCCC);
    check("mthi_mtlo_lo", bus.LoOut, 32'h0000_CCCC);
    bus.WrLoE = 1'b0; bus.WrDataE = 32'h0000_AAAA;
    tick();
    check("mthi_hi", bus.HiOut, 32'h0000_AAAA);
    check("mthi_lo_kept", bus.LoOut, 32'h0000_CCCC);
    bus.WrHiE = 1'b0; bus.WrLoE = 1'b1; bus.WrDataE = 32'h0000_BBBB;
    tick();
    check("mtlo_lo", bus.LoOut, 32'h0000_BBBB);
    check("mtlo_hi_kept", bus.HiOut, 32'h0000_AAAA);
    bus.WrLoE = 1'b0;

    // Flush a MULT at cycle 10
    bus.StartE = 1'b1; bus.MDOpE = 2'b00; bus.SrcAE = 32'd5; bus.SrcBE = 32'd6;
    tick();
    bus.StartE = 1'b0;
    check("flush_busy_started", bus.BusyE, 1'b1);
    repeat (9) tick();
    bus.FlushE = 1'b1;
    tick();
    bus.FlushE = 1'b0;
    check("flush_busy_low", bus.BusyE, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.DoneM) done_seen++;
      tick();
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hi_kept", bus.HiOut, 32'h0000_AAAA);
    check("flush_lo_kept", bus.LoOut, 32'h0000_BBBB);
    $display("flush mid-MULT -> hi=%h lo=%h", bus.HiOut, bus.LoOut);

    // Start and flush in the same idle cycle
    bus.StartE = 1'b1; bus.FlushE = 1'b1; bus.MDOpE = 2'b01; bus.SrcAE = 32'd2; bus.SrcBE = 32'd3;
    tick();
    bus.StartE = 1'b0; bus.FlushE = 1'b0;
    check("start_flush_busy", bus.BusyE, 1'b0);
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.DoneM) done_seen++;
      tick();
    end
    check("start_flush_no_done", 64'(done_seen), 64'd0);
    check("start_flush_lo", bus.LoOut, 32'h0000_BBBB);
    $display("start+flush -> busy=%b hi=%h lo=%h", bus.BusyE, bus.HiOut, bus.LoOut);

    // Table vectors
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b0, vecs[i].poke);
    end

    // Start with a simultaneous MTHI: the MTHI is dropped
    run_op(2'b01, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'hFFFF_FFFE, 1'b1, 1'b0);

    // Asynchronous reset during a DIV at cycle 12
    bus.StartE = 1'b1; bus.MDOpE = 2'b10; bus.SrcAE = 32'd100; bus.SrcBE = 32'd7;
    tick();
    bus.StartE = 1'b0;
    repeat (11) tick();
    reset_n = 1'b0;
    #1;
    check("midop_reset_hi", bus.HiOut, 32'h0);
    check("midop_reset_lo", bus.LoOut, 32'h0);
    check("midop_reset_busy", bus.BusyE, 1'b0);
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    bus.WrLoE = 1'b1; bus.WrDataE = 32'h0000_1234;
    tick();
    bus.WrLoE = 1'b0;
    check("post_reset_lo", bus.LoOut, 32'h0000_1234);
    check("post_reset_hi", bus.HiOut, 32'h0);
    check("post_reset_busy", bus.BusyE, 1'b0);
    $display("reset mid-DIV then MTLO -> hi=%h lo=%h", bus.HiOut, bus.LoOut);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
